// File: rtl/sift_pkg.sv
// Shared SIFT definitions: system-mode codes, Gaussian kernel geometry and the row-feeder
// FSM encoding used by the controller, line buffer and feeder.
package sift_pkg;

    localparam logic [2:0] SYS_IDLE          = 3'd0;
    localparam logic [2:0] SYS_GAUSSIAN      = 3'd1;
    localparam logic [2:0] SYS_DETECT_FILTER = 3'd2;
    localparam logic [2:0] SYS_COMPUTE_MATCH = 3'd3;
    localparam logic [2:0] SYS_END           = 3'd4;

    localparam int unsigned GAUSS_KSIZE = 7;
    localparam int unsigned GAUSS_PAD   = (GAUSS_KSIZE - 1) / 2;

    typedef enum logic [2:0] {
        StIdle,
        StPreZero,
        StRd,
        StPush,
        StPostZero,
        StDone
    } feeder_state_e;

endpackage

// File: rtl/gauss_row_feeder.sv
// Row-fetch sequencer for the Gaussian pass: PAD zero rows, IMG_ROWS SRAM rows, PAD zero rows,
// pushed into the line buffer with window-valid tagging. All outputs are registered.
module gauss_row_feeder
    import sift_pkg::*;
#(
    parameter int unsigned IMG_ROWS = 480,
    parameter int unsigned PAD      = GAUSS_PAD,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    output logic [2:0]        buffer_mode,
    output logic              buffer_we,
    output logic              fill_zero,
    output logic              row_valid,
    output logic [ADDR_W-1:0] row_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TotalPushes = IMG_ROWS + 2 * PAD;
    localparam int unsigned CntW        = $clog2(TotalPushes + 1);

    localparam logic [CntW-1:0]   PreDone  = CntW'(PAD);
    localparam logic [CntW-1:0]   PassDone = CntW'(TotalPushes);
    localparam logic [CntW-1:0]   WinStart = CntW'(2 * PAD);
    localparam logic [ADDR_W-1:0] LastRow  = ADDR_W'(IMG_ROWS - 1);

    feeder_state_e     state_q, state_d;
    logic [CntW-1:0]   push_cnt_q, push_cnt_d;
    logic [ADDR_W-1:0] fetch_cnt_q, fetch_cnt_d;

    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        mode_q, mode_d;
    logic              we_q, we_d;
    logic              fz_q, fz_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CntW-1:0]   pushed_cnt;
    logic              push_next;
    logic              zero_next;

    // Each edge decides the action of the coming cycle; a push is only committed when the
    // filter reports ready at that edge, otherwise the state simply holds.
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        done_d      = 1'b0;
        push_next   = 1'b0;
        zero_next   = 1'b0;
        // Pushes completed including the current cycle; also the index of the next push.
        pushed_cnt  = push_cnt_q + CntW'(we_q);
        push_cnt_d  = pushed_cnt;

        if (abort) begin
            state_d     = StIdle;
            push_cnt_d  = '0;
            fetch_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StPreZero;
                        push_next = out_ready;
                        zero_next = 1'b1;
                    end
                end
                StPreZero: begin
                    if (pushed_cnt == PreDone) begin
                        state_d   = StRd;
                        rd_en_d   = 1'b1;
                        rd_addr_d = fetch_cnt_q;
                    end else begin
                        push_next = out_ready;
                        zero_next = 1'b1;
                    end
                end
                StRd: begin
                    state_d   = StPush;
                    push_next = out_ready;
                end
                StPush: begin
                    if (!we_q) begin
                        push_next = out_ready;
                    end else if (fetch_cnt_q != LastRow) begin
                        state_d     = StRd;
                        fetch_cnt_d = fetch_cnt_q + ADDR_W'(1);
                        rd_en_d     = 1'b1;
                        rd_addr_d   = fetch_cnt_q + ADDR_W'(1);
                    end else begin
                        state_d   = StPostZero;
                        push_next = out_ready;
                        zero_next = 1'b1;
                    end
                end
                StPostZero: begin
                    if (pushed_cnt == PassDone) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        push_cnt_d  = '0;
                        fetch_cnt_d = '0;
                    end else begin
                        push_next = out_ready;
                        zero_next = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d     = StIdle;
                    push_cnt_d  = '0;
                    fetch_cnt_d = '0;
                end
            endcase
        end

        we_d    = push_next;
        fz_d    = push_next & zero_next;
        valid_d = push_next && (pushed_cnt >= WinStart);
        idx_d   = valid_d ? ADDR_W'(pushed_cnt - WinStart) : '0;
        busy_d  = (state_d != StIdle);
        mode_d  = busy_d ? SYS_GAUSSIAN : SYS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            push_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            mode_q      <= SYS_IDLE;
            we_q        <= 1'b0;
            fz_q        <= 1'b0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            push_cnt_q  <= push_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            mode_q      <= mode_d;
            we_q        <= we_d;
            fz_q        <= fz_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sram_rd_en   = rd_en_q;
    assign sram_rd_addr = rd_addr_q;
    assign buffer_mode  = mode_q;
    assign buffer_we    = we_q;
    assign fill_zero    = fz_q;
    assign row_valid    = valid_q;
    assign row_idx      = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/gauss_row_feeder.md
# gauss_row_feeder

Row-fetch sequencer for the Gaussian pass. It reads image rows from the image SRAM in order, adds zero rows above and below the image, and drives the line buffer's `buffer_mode`, `buffer_we` and `fill_zero` controls. It also tells the downstream Gaussian filter when a full vertical window is present and which output row it is centred on. It sits between the system controller and the 10-row line buffer.

## Interface
- `IMG_ROWS`, 480: image height in rows.
- `PAD`, 3: zero rows added above and below the image; the vertical window is 2*PAD+1 rows.
- `ADDR_W`, 9: SRAM row-address width; must satisfy 2^ADDR_W ≥ IMG_ROWS.
- `clk  input  1`: system clock.
- `rst_n  input  1`: reset. Synchronous and active-high: `rst_n=1` resets the block at a rising edge of `clk`. The port name is kept as the codebase does.
- `start  input  1`: one-cycle pulse that begins a pass. Ignored unless the FSM is in IDLE.
- `abort  input  1`: returns the FSM to IDLE on the next edge.
- `out_ready  input  1`: downstream filter can accept a window this cycle.
- `sram_rd_en  output  1`: read strobe to the image SRAM.
- `sram_rd_addr  output  ADDR_W`: row address to read.
- `buffer_mode  output  3`: `SYS_IDLE`=0 or `SYS_GAUSSIAN`=1, driven to the line buffer.
- `buffer_we  output  1`: shift/write strobe to the line buffer.
- `fill_zero  output  1`: write zero into line-buffer row 0.
- `row_valid  output  1`: a complete window is being pushed this cycle.
- `row_idx  output  ADDR_W`: output row index centred in the current window.
- `busy  output  1`: FSM is not in IDLE.
- `done  output  1`: one-cycle pulse at the end of a pass.

## Operation
- FSM states:
  - IDLE → PRE_ZERO on `start`.
  - PRE_ZERO: PAD zero pushes, then → RD.
  - RD: asserts `sram_rd_en` and `sram_rd_addr=fetch_cnt` for one cycle → PUSH.
  - PUSH: waits for `out_ready`, then pushes the row; → RD if `fetch_cnt<IMG_ROWS-1`, else → POST_ZERO.
  - POST_ZERO: PAD zero pushes → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Push definition:
  - A push is one cycle with `buffer_we=1`.
  - In a zero push, `fill_zero=1` as well.
  - Pushes happen only when `out_ready=1`; otherwise every control output is held at 0 and the state is unchanged.
- SRAM contract: read latency is exactly 1 cycle, and read data stays stable until the next `sram_rd_en`. PUSH therefore always sees valid `img_data`.
- Counters:
  - `push_cnt` counts from 0 to IMG_ROWS+2*PAD-1.
  - `fetch_cnt` counts from 0 to IMG_ROWS-1.
- Window output:
  - `row_valid=buffer_we && push_cnt≥2*PAD`.
  - `row_idx=push_cnt-2*PAD`; it is 0 whenever `row_valid=0`.
  - A pass therefore produces exactly IMG_ROWS `row_valid` pulses, for rows 0..IMG_ROWS-1 in order.
- `buffer_mode` is `SYS_GAUSSIAN` in every non-IDLE state and `SYS_IDLE` in IDLE, so the line buffer is cleared between passes.
- `abort` beats `start`, and beats `out_ready` if both arrive in the same cycle. Abort does not assert `done`.
- `start` while busy has no effect.
- `IMG_ROWS` < 1 is illegal.

## Timing
- Reset values: `sram_rd_en=0`, `sram_rd_addr=0`, `buffer_mode=SYS_IDLE`, `buffer_we=0`, `fill_zero=0`, `row_valid=0`, `row_idx=0`, `busy=0`, `done=0`; both counters 0; state IDLE.
- All outputs are registered.
- `start` seen at edge t gives the first zero push in cycle t+1.
- With `out_ready` held at 1, a pass takes PAD + 2*IMG_ROWS + PAD + 1 cycles from the first push to `done`.
- The first `row_valid` occurs on push 2*PAD+1, which is the PUSH of SRAM row PAD.
- `done` and `busy` drop together: `busy` is 0 in the cycle after `done`. A `start` in the cycle after `done` is accepted.
- Reset or `abort` mid-pass:
  - Next cycle the block is in IDLE with all outputs at reset values.
  - `buffer_mode=SYS_IDLE` clears the line buffer.
  - No partial row is pushed.
- Stall in RD: not possible, since RD never waits. A stall in PUSH does not re-issue the read.

## Structure
- Shared package `sift_pkg` holds:
  - the `SYS_IDLE`/`SYS_GAUSSIAN`/`SYS_DETECT_FILTER`/`SYS_COMPUTE_MATCH`/`SYS_END` constants;
  - the FSM state encoding.
  Both are shared with the line buffer and the system controller.
- `PAD` derives from the Gaussian kernel size, which is also defined in `sift_pkg`.
- Single module; no sub-module required.

## Test plan
- IMG_ROWS=8, PAD=3, `out_ready=1`, pulse `start`:
  - pushes in order: 3 zero, 8 SRAM (addresses 0..7), 3 zero;
  - `row_valid` on pushes 7..14 with `row_idx` 0..7;
  - `done` at cycle 23 after `start`.
- Same pass with `out_ready` low for 5 cycles during the PUSH of row 4:
  - `buffer_we` stays 0 for those 5 cycles;
  - `sram_rd_en` pulses once for address 4;
  - the pass ends 5 cycles later.
- `abort` during the PUSH of row 5:
  - next cycle `buffer_mode=0`, `busy=0`, no `done`;
  - a fresh `start` restarts from address 0.
- `rst_n=1` during POST_ZERO: all outputs at reset values the next cycle.
- `start` pulsed while busy: no effect on counts. `start` in the cycle after `done`: a new pass begins.
- IMG_ROWS=1: 1 read, 7 pushes, a single `row_valid` with `row_idx=0`.
